// File: rtl/vram_pkg.sv
// vram_pkg: shared VRAM widths, depth and arbiter state encoding
package vram_pkg;
  localparam int VRAM_ADDR_W = 14;
  localparam int VRAM_DATA_W = 16;
  localparam int VRAM_DEPTH = 8192;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK = 2'd1,
    WAIT_DROP = 2'd2
  } vram_state_t;
endpackage

// File: rtl/vram_spram.sv
// vram_spram: single-port 16K x 16 RAM with SB_SPRAM256KA timing (full-word writes, registered read)
module vram_spram import vram_pkg::*; #(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              we,
  input  logic              re,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  // One access per cycle: a write leaves the output register untouched
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
    else if (re) rdata <= mem[addr];
endmodule

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: display reads win the SPRAM; writes commit in read-free cycles and are acked once
module vram_port_arbiter import vram_pkg::*; #(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W,
  parameter int DEPTH = VRAM_DEPTH,
  parameter int STARVE_LIMIT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rden,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic              wren,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic              wrack,
  output logic              write_starved
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 2);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STARVE_LIMIT + 1);
  vram_state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [DATA_W-1:0] hold, mem_rdata;
  logic r_in, w_in, commit, rd_q, clr_q;
  assign r_in = 32'(raddr) < DEPTH;
  assign w_in = 32'(waddr) < DEPTH;
  assign commit = state == IDLE && wren && !rden;
  assign write_starved = cnt > CNT_W'(STARVE_LIMIT);
  assign rdata = rd_q ? mem_rdata : clr_q ? '0 : hold;
  // Write handshake sequencing: commit, one-cycle ack, then wait for the late drop of wren
  always_comb begin
    state_n = state;
    wrack = 1'b0;
    state_n = state == IDLE ? (commit ? ACK : IDLE) : state == ACK ? WAIT_DROP : (wren ? WAIT_DROP : IDLE);
    wrack = state == ACK;
  end
  // State, starve counter and read-return bookkeeping
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      rd_q <= 1'b0;
      clr_q <= 1'b0;
      hold <= '0;
    end else begin
      state <= state_n;
      cnt <= (state == IDLE && wren && rden) ? (cnt == CNT_SAT ? cnt : cnt + 1'b1) : '0;
      rd_q <= rden && r_in;
      clr_q <= rden && !r_in;
      hold <= rdata;
    end
  vram_spram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_spram (
    .clk(clk),
    .addr(rden ? raddr : waddr),
    .wdata(wdata),
    .we(commit && w_in),
    .re(rden && r_in),
    .rdata(mem_rdata)
  );
endmodule

// File: tb/tb_vram_port_arbiter.sv
// tb_vram_port_arbiter: randomized read/write traffic against a word-level memory and handshake model
module tb_vram_port_arbiter;
  import vram_pkg::*;
  localparam int LIMIT = 15;
  localparam int DEPTH = VRAM_DEPTH;
  logic clk = 1'b0, reset = 1'b1, rden = 1'b0, wren = 1'b0;
  logic [13:0] raddr = '0, waddr = '0;
  logic [15:0] wdata = '0, rdata;
  logic wrack, write_starved;
  int checks = 0, errors = 0;
  int mdl [int];
  int exp_rdata = 0, blocked = 0;
  bit exp_known = 1, acked = 0, need_drop = 0;

  always #5 clk = ~clk;

  vram_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .rden(rden), .raddr(raddr), .rdata(rdata),
    .wren(wren), .waddr(waddr), .wdata(wdata), .wrack(wrack), .write_starved(write_starved)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] rnd_addr();
    return ($urandom_range(0, 9) == 0) ? 14'($urandom_range(32'h1FFE, 32'h2001)) : 14'($urandom_range(0, 63));
  endfunction

  task automatic cycle(input bit rd, input logic [13:0] ra, input bit wr, input logic [13:0] wa, input logic [15:0] wd);
    rden = rd; raddr = ra; wren = wr; waddr = wa; wdata = wd;
    if (rd) begin
      if (int'(ra) >= DEPTH) begin exp_rdata = 0; exp_known = 1; end
      else if (mdl.exists(int'(ra))) begin exp_rdata = mdl[int'(ra)]; exp_known = 1; end
      else exp_known = 0;
    end
    if (acked) begin acked = 0; need_drop = 1; end
    else if (need_drop) need_drop = wr;
    else if (wr && !rd) begin
      if (int'(wa) < DEPTH) mdl[int'(wa)] = int'(wd);
      acked = 1;
      blocked = 0;
    end
    else if (wr) blocked = (blocked > LIMIT) ? blocked : blocked + 1;
    else blocked = 0;
    @(posedge clk); #1;
    check("wrack", 32'(wrack), 32'(acked));
    check("write_starved", 32'(write_starved), 32'(blocked > LIMIT));
    if (exp_known) check("rdata", 32'(rdata), exp_rdata);
  endtask

  task automatic write_txn(input logic [13:0] wa, input logic [15:0] wd, input int block, input int pct);
    int n = 0;
    bit rd;
    while (wrack !== 1'b1 && n < 300) begin
      rd = (n < block) || ($urandom_range(0, 99) < pct);
      cycle(rd, rnd_addr(), 1, wa, wd);
      n++;
    end
    check("write_timeout", 32'(wrack), 32'd1);
    repeat ($urandom_range(1, 2)) cycle($urandom_range(0, 1) == 1, rnd_addr(), 1, wa, wd);
    cycle($urandom_range(0, 1) == 1, rnd_addr(), 0, wa, wd);
  endtask

  task automatic reset_now();
    rden = 0; wren = 0;
    reset = 1;
    exp_rdata = 0; exp_known = 1; acked = 0; need_drop = 0; blocked = 0;
    #1;
    check("rst_wrack", 32'(wrack), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_starved", 32'(write_starved), 32'd0);
    @(posedge clk); #1;
    reset = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_wrack", 32'(wrack), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_starved", 32'(write_starved), 32'd0);
    reset = 0;
    cycle(1, 14'h0005, 0, '0, '0);
    cycle(1, 14'h2000, 0, '0, '0);
    write_txn(14'h0010, 16'hFFFF, 0, 0);
    cycle(1, 14'h0010, 0, '0, '0);
    cycle(0, '0, 0, '0, '0);
    write_txn(14'h0020, 16'hA5A5, 20, 0);
    cycle(1, 14'h0020, 0, '0, '0);
    cycle(1, 14'h0010, 0, '0, '0);
    write_txn(14'h2000, 16'h1234, 0, 0);
    cycle(1, 14'h2000, 0, '0, '0);
    cycle(0, '0, 1, 14'h0030, 16'h5A5A);
    cycle(1, 14'h0030, 1, 14'h0030, 16'h5A5A);
    cycle(0, '0, 0, '0, '0);
    repeat (5) cycle(1, rnd_addr(), 1, 14'h0010, 16'hBEEF);
    cycle(0, '0, 0, '0, '0);
    cycle(1, 14'h0010, 0, '0, '0);
    cycle(0, '0, 1, 14'h0040, 16'h4444);
    reset_now();
    cycle(1, 14'h0040, 0, '0, '0);
    cycle(0, '0, 1, 14'h0041, 16'h4141);
    cycle(0, '0, 1, 14'h0041, 16'h4141);
    reset_now();
    cycle(1, 14'h0041, 0, '0, '0);
    repeat (3) cycle(1, rnd_addr(), 1, 14'h0010, 16'hDEAD);
    reset_now();
    cycle(1, 14'h0010, 0, '0, '0);
    repeat (60) begin
      if ($urandom_range(0, 2) == 0)
        write_txn(rnd_addr(), 16'($urandom), ($urandom_range(0, 3) == 0) ? 20 : 0, int'($urandom_range(0, 80)));
      else
        repeat ($urandom_range(1, 4)) cycle($urandom_range(0, 1) == 1, rnd_addr(), 0, '0, '0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
Responder for the VRAM write handshake (wren/waddr/wdata -> wrack) and the VGA read port (rden/raddr -> rdata).
Multiplexes both requesters onto one single-port 16K x 16 SPRAM.
Display reads always win; writes are committed only in cycles with no read, then acknowledged with a one-cycle wrack pulse.
Sits between the display controller and the write-side logic in the top level.

Parameters:
ADDR_W, 14, address width of both ports
DATA_W, 16, data word width
DEPTH, 8192, valid words (0x0000..0x1FFF); higher addresses are out of range
STARVE_LIMIT, 1023, consecutive read-blocked cycles before write_starved asserts

Ports:
clk  input  1  system clock (PLL output)
reset  input  1  asynchronous, active-high reset
rden  input  1  read request, sampled every cycle
raddr  input  ADDR_W  read address, valid with rden
rdata  output  DATA_W  read data, valid one cycle after rden
wren  input  1  write request level, held by requester until wrack seen
waddr  input  ADDR_W  write address, stable while wren high
wdata  input  DATA_W  write data, stable while wren high
wrack  output  1  one-cycle pulse: write committed
write_starved  output  1  pending write blocked by reads for more than STARVE_LIMIT cycles

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: state=IDLE, wrack=0, rdata=0, write_starved=0, starve counter=0. Memory contents are not cleared.
- Reset mid-write: an uncommitted write is dropped and no wrack is produced. A committed write stays in memory.
- Read path: a cycle with rden=1 issues an SPRAM read of raddr.
  - rdata is updated on the next edge (latency 1).
  - When rden=0, rdata holds its last value.
  - If raddr >= DEPTH, no SPRAM access occurs and rdata=0 next cycle.
- Read priority: rden=1 always owns the SPRAM that cycle, even when a write is pending.
- States:
  - IDLE: if wren=1 and rden=0, write waddr/wdata this cycle and go to ACK. If wren=1 and rden=1, stay in IDLE and increment the starve counter (saturating).
  - ACK: wrack=1 for exactly this cycle; go to WAIT_DROP. No memory write.
  - WAIT_DROP: wrack=0; ignore wren while it is still high (requester drops it one cycle late); return to IDLE on the first cycle wren=0.
- Each wren assertion produces exactly one write and exactly one wrack.
- Abort: if wren falls in IDLE before commit, no write occurs and the starve counter clears.
- Out-of-range write (waddr >= DEPTH): memory is untouched, but the normal ACK sequence is still performed.
- write_starved:
  - Rises when the starve counter exceeds STARVE_LIMIT.
  - Clears on commit or abort.
  - Status only; it never preempts reads.
- Read after write: a read of the same address issued the cycle after commit (ACK state) returns the new data.
- Write commit and read are mutually exclusive per cycle: SPRAM WREN=1 only when rden=0.

Decomposition:
- Shared package vram_pkg: VRAM_ADDR_W=14, VRAM_DATA_W=16, VRAM_DEPTH=8192 (0x2000), and the state encoding (IDLE=2'd0, ACK=2'd1, WAIT_DROP=2'd2).
- One sub-module, vram_spram: a thin wrapper around a single SB_SPRAM256KA exposing addr/wdata/we/rdata. It keeps MASKWREN=4'b1111, CHIPSELECT=1, POWEROFF=1 and the other power pins inactive. The arbiter owns all sequencing.

Test Plan:
- Reset then rden=1, raddr=0x0005, no writes -> rdata=0x0000 one cycle later; wrack stays 0.
- rden=0, wren=1, waddr=0x0010, wdata=0xFFFF; requester drops wren one cycle after seeing wrack -> write committed in cycle 0, wrack high in cycle 1 only, no second write. A later read of 0x0010 returns 0xFFFF.
- rden=1 for 20 cycles while wren=1, waddr=0x0020, wdata=0xA5A5 -> no write and no wrack during reads; commit on the first rden=0 cycle, wrack the next cycle; reads of other addresses are undisturbed.
- With STARVE_LIMIT=15, rden=1 continuously and wren=1 -> write_starved=1 after 16 blocked cycles. Dropping rden commits the write, pulses wrack, and clears write_starved.
- wren=1, waddr=0x2000, wdata=0x1234 with rden=0 -> wrack pulses once, no memory change; a read of 0x2000 returns 0x0000.
- Reset asserted while in ACK or WAIT_DROP -> wrack falls immediately, state=IDLE; the committed data is still readable after reset release.
